// File: rtl/npc_mc_pkg.sv
// Shared definitions for the multi-cycle NPC core: opcodes, FSM states, EBREAK encoding.
package npc_pkg;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] SYSTEM = 7'b1110011;

    localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

    typedef enum logic [1:0] {
        FETCH,
        WAIT,
        EXEC,
        HALT
    } state_t;

endpackage

// File: rtl/npc_mc_if.sv
// Instruction fetch port: request handshake plus a separate response-valid strobe.
interface npc_mc_if;

    logic        ifu_req_valid;
    logic        ifu_req_ready;
    logic [31:0] ifu_addr;
    logic        ifu_rsp_valid;
    logic [31:0] ifu_rdata;

    modport master (
        output ifu_req_valid,
        output ifu_addr,
        input  ifu_req_ready,
        input  ifu_rsp_valid,
        input  ifu_rdata
    );

    modport slave (
        input  ifu_req_valid,
        input  ifu_addr,
        output ifu_req_ready,
        output ifu_rsp_valid,
        output ifu_rdata
    );

endinterface

// File: rtl/npc_mc_regfile.sv
// Integer register file: two async read ports, one sync write port, fixed x10 tap.
module npc_mc_regfile #(
    parameter int unsigned NR_REGS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    output logic [31:0] x10,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd
);

    localparam int unsigned AW = $clog2(NR_REGS);

    logic [31:0] regs [NR_REGS];

    // Clear every register on reset; writes to x0 or out-of-range indices are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NR_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && wa != 5'd0 && {27'b0, wa} < NR_REGS) begin
            regs[wa[AW-1:0]] <= wd;
        end
    end

    // Reads of x0 or of non-existent registers return zero.
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (ra1 != 5'd0 && {27'b0, ra1} < NR_REGS) rd1 = regs[ra1[AW-1:0]];
        if (ra2 != 5'd0 && {27'b0, ra2} < NR_REGS) rd2 = regs[ra2[AW-1:0]];
    end

    assign x10 = regs[10];

endmodule

// File: rtl/npc_mc.sv
// Multi-cycle NPC core: FETCH/WAIT/EXEC/HALT sequencing, decode, ALU and commit reporting.
module npc_mc
    import npc_pkg::*;
#(
    parameter logic [31:0] RESET_PC      = 32'h8000_0000,
    parameter int unsigned NR_REGS       = 32,
    parameter int unsigned FETCH_TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        rst,
    npc_mc_if.master    ifu,
    output logic [31:0] pc,
    output logic        commit_valid,
    output logic [31:0] commit_pc,
    output logic [31:0] commit_inst,
    output logic        halt,
    output logic        trap,
    output logic [31:0] halt_code
);

    state_t      state_q, state_d;
    logic [31:0] pc_q, inst_q, wait_cnt_q, halt_code_q;
    logic        trap_q;

    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm_i, imm_u, imm_j;
    logic [31:0] rs1_val, rs2_val, x10_val;
    logic [31:0] wr_data, next_pc;
    logic        legal, is_ebreak, use_rd, use_rs1, use_rs2, bad_idx, illegal, wr_en;

    assign opcode = inst_q[6:0];
    assign rd     = inst_q[11:7];
    assign funct3 = inst_q[14:12];
    assign rs1    = inst_q[19:15];
    assign rs2    = inst_q[24:20];
    assign funct7 = inst_q[31:25];
    assign imm_i  = {{20{inst_q[31]}}, inst_q[31:20]};
    assign imm_u  = {inst_q[31:12], 12'b0};
    assign imm_j  = {{11{inst_q[31]}}, inst_q[31], inst_q[19:12], inst_q[20], inst_q[30:21], 1'b0};

    npc_mc_regfile #(
        .NR_REGS(NR_REGS)
    ) u_regfile (
        .clk (clk),
        .rst (rst),
        .ra1 (rs1),
        .ra2 (rs2),
        .rd1 (rs1_val),
        .rd2 (rs2_val),
        .x10 (x10_val),
        .we  (wr_en),
        .wa  (rd),
        .wd  (wr_data)
    );

    // Decode and execute the latched instruction; JALR uses the pre-writeback rs1.
    always_comb begin
        legal     = 1'b0;
        is_ebreak = 1'b0;
        use_rd    = 1'b0;
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        wr_data   = '0;
        next_pc   = pc_q + 32'd4;
        unique case (opcode)
            OP_IMM: if (funct3 == 3'b000) begin
                legal   = 1'b1;
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                wr_data = rs1_val + imm_i;
            end
            OP: if (funct3 == 3'b000 && funct7 == 7'b0) begin
                legal   = 1'b1;
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                wr_data = rs1_val + rs2_val;
            end
            LUI: begin
                legal   = 1'b1;
                use_rd  = 1'b1;
                wr_data = imm_u;
            end
            AUIPC: begin
                legal   = 1'b1;
                use_rd  = 1'b1;
                wr_data = pc_q + imm_u;
            end
            JAL: begin
                legal   = 1'b1;
                use_rd  = 1'b1;
                wr_data = pc_q + 32'd4;
                next_pc = pc_q + imm_j;
            end
            JALR: if (funct3 == 3'b000) begin
                legal   = 1'b1;
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                wr_data = pc_q + 32'd4;
                next_pc = (rs1_val + imm_i) & ~32'd1;
            end
            SYSTEM: if (inst_q == EBREAK_INST) begin
                legal     = 1'b1;
                is_ebreak = 1'b1;
            end
            default: ;
        endcase
        bad_idx = (use_rd  && {27'b0, rd}  >= NR_REGS) ||
                  (use_rs1 && {27'b0, rs1} >= NR_REGS) ||
                  (use_rs2 && {27'b0, rs2} >= NR_REGS);
        illegal = !legal || bad_idx || inst_q[1:0] != 2'b11;
        wr_en   = state_q == EXEC && !illegal && use_rd;
    end

    // Next-state logic for the fetch/execute sequencer, including the optional fetch timeout.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FETCH: if (ifu.ifu_req_ready) state_d = WAIT;
            WAIT: begin
                if (ifu.ifu_rsp_valid) begin
                    state_d = EXEC;
                end else if (FETCH_TIMEOUT != 0 && wait_cnt_q == FETCH_TIMEOUT - 1) begin
                    state_d = HALT;
                end
            end
            EXEC:    state_d = (illegal || is_ebreak) ? HALT : FETCH;
            HALT:    state_d = HALT;
            default: state_d = FETCH;
        endcase
    end

    // Architectural state update; halt cause and x10 are captured on entry to HALT.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FETCH;
            pc_q        <= RESET_PC;
            inst_q      <= '0;
            wait_cnt_q  <= '0;
            trap_q      <= 1'b0;
            halt_code_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == FETCH) wait_cnt_q <= '0;
            else if (state_q == WAIT) wait_cnt_q <= wait_cnt_q + 32'd1;
            if (state_q == WAIT && ifu.ifu_rsp_valid) inst_q <= ifu.ifu_rdata;
            if (state_q == EXEC && !illegal) pc_q <= next_pc;
            if (state_d == HALT && state_q != HALT) begin
                trap_q      <= (state_q == EXEC) ? illegal : 1'b1;
                halt_code_q <= x10_val;
            end
        end
    end

    assign ifu.ifu_req_valid = state_q == FETCH;
    assign ifu.ifu_addr      = pc_q;
    assign pc                = pc_q;
    assign commit_valid      = state_q == EXEC;
    assign commit_pc         = pc_q;
    assign commit_inst       = inst_q;
    assign halt              = state_q == HALT;
    assign trap              = trap_q;
    assign halt_code         = halt_code_q;

endmodule

// File: tb/tb_npc_mc.sv
// Self-checking bench for npc_mc: randomized programs against an ISS with a commit scoreboard,
// plus directed RV32E, timeout and reset-during-fetch scenarios on a second instance.
module tb_npc_mc;
    import npc_pkg::*;

    localparam logic [31:0] RPC = 32'h8000_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a = 1'b1;
    logic rst_b = 1'b1;

    npc_mc_if bus_a ();
    npc_mc_if bus_b ();

    logic [31:0] a_pc, a_cpc, a_cinst, a_hcode, b_pc, b_cpc, b_cinst, b_hcode;
    logic        a_cv, a_halt, a_trap, b_cv, b_halt, b_trap;

    npc_mc #(.RESET_PC(RPC), .NR_REGS(32), .FETCH_TIMEOUT(0)) dut_a (
        .clk(clk), .rst(rst_a), .ifu(bus_a), .pc(a_pc), .commit_valid(a_cv),
        .commit_pc(a_cpc), .commit_inst(a_cinst), .halt(a_halt), .trap(a_trap),
        .halt_code(a_hcode)
    );

    npc_mc #(.RESET_PC(RPC), .NR_REGS(16), .FETCH_TIMEOUT(8)) dut_b (
        .clk(clk), .rst(rst_b), .ifu(bus_b), .pc(b_pc), .commit_valid(b_cv),
        .commit_pc(b_cpc), .commit_inst(b_cinst), .halt(b_halt), .trap(b_trap),
        .halt_code(b_hcode)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference machine state for dut_a
    logic [31:0] mregs [32];
    logic [31:0] mpc;
    logic [63:0] exp_q [$];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, 3'b000, rd, op};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [4:0] rd);
        return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    // ISS step: kind 0 = normal, 1 = ebreak, 2 = illegal (no architectural change)
    task automatic model_step(input logic [31:0] inst, output int kind);
        logic [31:0] a, b, res, npc, iimm, jimm;
        logic        wr;
        a    = mregs[inst[19:15]];
        b    = mregs[inst[24:20]];
        iimm = {{20{inst[31]}}, inst[31:20]};
        jimm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
        npc  = mpc + 4;
        res  = 0;
        wr   = 1'b0;
        kind = 0;
        if (inst == 32'h0010_0073) kind = 1;
        else if (inst[1:0] != 2'b11) kind = 2;
        else begin
            case (inst[6:0])
                7'h13: if (inst[14:12] == 0) begin wr = 1; res = a + iimm; end else kind = 2;
                7'h33: if (inst[14:12] == 0 && inst[31:25] == 0) begin wr = 1; res = a + b; end
                       else kind = 2;
                7'h37: begin wr = 1; res = {inst[31:12], 12'h000}; end
                7'h17: begin wr = 1; res = mpc + {inst[31:12], 12'h000}; end
                7'h6f: begin wr = 1; res = mpc + 4; npc = mpc + jimm; end
                7'h67: if (inst[14:12] == 0) begin
                           wr = 1; res = mpc + 4; npc = (a + iimm) & 32'hFFFF_FFFE;
                       end else kind = 2;
                default: kind = 2;
            endcase
        end
        if (kind != 2) begin
            if (wr && inst[11:7] != 0) mregs[inst[11:7]] = res;
            mpc = npc;
        end
    endtask

    function automatic logic [31:0] rand_inst();
        logic [4:0]  rd, rs1, rs2;
        logic [11:0] i12;
        logic [19:0] u20;
        logic [20:0] j21;
        int unsigned k;
        k   = $urandom_range(0, 9);
        rd  = 5'($urandom);
        rs1 = 5'($urandom);
        rs2 = 5'($urandom);
        i12 = 12'($urandom);
        u20 = 20'($urandom);
        j21 = 21'($urandom) & 21'h1F_FFFE;
        case (k)
            0, 1, 2, 3: return enc_i(i12, rs1, rd, 7'b0010011);
            4, 5:       return enc_r(rs2, rs1, rd);
            6:          return {u20, rd, 7'b0110111};
            7:          return {u20, rd, 7'b0010111};
            8:          return enc_j(j21, rd);
            default:    return enc_i(i12, rs1, rd, 7'b1100111);
        endcase
    endfunction

    function automatic logic [31:0] rand_illegal();
        case ($urandom_range(0, 3))
            0:       return {7'b0100000, 5'd3, 5'd2, 3'b000, 5'd1, 7'b0110011};
            1:       return 32'h0000_2083;
            2:       return 32'h0050_0090;
            default: return {12'd5, 5'd1, 3'b010, 5'd2, 7'b0010011};
        endcase
    endfunction

    // Scoreboard monitor: every commit of dut_a must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst_a && a_cv) begin
            if (exp_q.size() == 0) begin
                check32("unexpected_commit", a_cinst, 32'hxxxx_xxxx);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check32("commit_pc", a_cpc, e[63:32]);
                check32("commit_inst", a_cinst, e[31:0]);
                check32("pc_during_exec", a_pc, e[63:32]);
            end
        end
    end

    task automatic reset_a();
        check32("pending_commits", exp_q.size(), 0);
        exp_q.delete();
        rst_a = 1'b1;
        bus_a.ifu_req_ready = 1'b0;
        bus_a.ifu_rsp_valid = 1'b0;
        repeat (2) @(negedge clk);
        check32("a_rst_pc", a_pc, RPC);
        check32("a_rst_halt", {31'b0, a_halt}, 0);
        check32("a_rst_trap", {31'b0, a_trap}, 0);
        check32("a_rst_commit", {31'b0, a_cv}, 0);
        for (int i = 0; i < 32; i++) mregs[i] = 0;
        mpc   = RPC;
        rst_a = 1'b0;
    endtask

    task automatic fetch_a(input logic [31:0] inst, input bit fast, output int kind);
        int k, stall, d;
        bus_a.ifu_rsp_valid = 1'b0;
        bus_a.ifu_req_ready = 1'b0;
        kind = 2;
        k = 0;
        while (!bus_a.ifu_req_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        check32("req_seen", {31'b0, bus_a.ifu_req_valid}, 1);
        if (!bus_a.ifu_req_valid) return;
        stall = fast ? 0 : $urandom_range(0, 4);
        for (int i = 0; i < stall; i++) begin
            bus_a.ifu_rsp_valid = ($urandom_range(0, 1) == 1);
            bus_a.ifu_rdata     = $urandom;
            @(negedge clk);
            bus_a.ifu_rsp_valid = 1'b0;
            check32("req_hold_valid", {31'b0, bus_a.ifu_req_valid}, 1);
            check32("req_hold_addr", bus_a.ifu_addr, mpc);
        end
        check32("fetch_addr", bus_a.ifu_addr, mpc);
        exp_q.push_back({mpc, inst});
        model_step(inst, kind);
        bus_a.ifu_req_ready = 1'b1;
        @(negedge clk);
        bus_a.ifu_req_ready = 1'b0;
        d = fast ? 0 : $urandom_range(0, 3);
        repeat (d) @(negedge clk);
        bus_a.ifu_rsp_valid = 1'b1;
        bus_a.ifu_rdata     = inst;
        @(negedge clk);
        bus_a.ifu_rsp_valid = 1'b0;
    endtask

    task automatic finish_run_a(input int kind);
        @(negedge clk);
        check32("a_halt", {31'b0, a_halt}, 1);
        check32("a_trap", {31'b0, a_trap}, (kind == 2) ? 1 : 0);
        check32("a_halt_code", a_hcode, mregs[10]);
        check32("a_halt_pc", a_pc, mpc);
        bus_a.ifu_req_ready = 1'b1;
        repeat (20) begin
            @(negedge clk);
            check32("a_no_req_in_halt", {31'b0, bus_a.ifu_req_valid}, 0);
        end
        bus_a.ifu_req_ready = 1'b0;
    endtask

    task automatic reset_b();
        rst_b = 1'b1;
        bus_b.ifu_req_ready = 1'b0;
        bus_b.ifu_rsp_valid = 1'b0;
        repeat (2) @(negedge clk);
        check32("b_rst_pc", b_pc, RPC);
        check32("b_rst_halt", {31'b0, b_halt}, 0);
        check32("b_rst_trap", {31'b0, b_trap}, 0);
        check32("b_rst_code", b_hcode, 0);
        rst_b = 1'b0;
    endtask

    task automatic b_exec(input logic [31:0] inst);
        int k;
        bus_b.ifu_req_ready = 1'b1;
        k = 0;
        while (!bus_b.ifu_req_valid && k < 10) begin
            @(negedge clk);
            k++;
        end
        check32("b_req_seen", {31'b0, bus_b.ifu_req_valid}, 1);
        @(negedge clk);
        bus_b.ifu_req_ready = 1'b0;
        bus_b.ifu_rsp_valid = 1'b1;
        bus_b.ifu_rdata     = inst;
        @(negedge clk);
        bus_b.ifu_rsp_valid = 1'b0;
        check32("b_commit_valid", {31'b0, b_cv}, 1);
        check32("b_commit_inst", b_cinst, inst);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int kind;
        logic [31:0] prog [$];
        bus_a.ifu_req_ready = 1'b0;
        bus_a.ifu_rsp_valid = 1'b0;
        bus_a.ifu_rdata     = '0;
        bus_b.ifu_req_ready = 1'b0;
        bus_b.ifu_rsp_valid = 1'b0;
        bus_b.ifu_rdata     = '0;

        for (int run = 0; run < 14; run++) begin
            reset_a();
            prog.delete();
            if (run == 0) begin
                prog.push_back(enc_i(12'd42, 5'd0, 5'd10, 7'b0010011));
                prog.push_back(EBREAK_INST);
            end else if (run == 1) begin
                prog.push_back({20'h80000, 5'd10, 7'b0110111});
                prog.push_back(enc_i(12'h101, 5'd10, 5'd0, 7'b1100111));
                prog.push_back(enc_j(21'd8, 5'd10));
                prog.push_back(enc_i(12'd4, 5'd10, 5'd10, 7'b1100111));
                prog.push_back(enc_i(12'd7, 5'd10, 5'd0, 7'b0010011));
                prog.push_back(enc_r(5'd0, 5'd10, 5'd10));
                prog.push_back(EBREAK_INST);
            end else begin
                int n;
                n = $urandom_range(15, 40);
                for (int i = 0; i < n; i++) prog.push_back(rand_inst());
                prog.push_back(enc_r(5'($urandom), 5'($urandom), 5'd10));
                prog.push_back(($urandom_range(0, 1) == 0) ? EBREAK_INST : rand_illegal());
            end
            kind = 0;
            foreach (prog[i]) begin
                if (kind == 0) fetch_a(prog[i], run < 2 || $urandom_range(0, 3) == 0, kind);
            end
            finish_run_a(kind);
        end
        reset_a();

        // Immediate handshake timing, then x1 observed through x10 at EBREAK
        reset_b();
        bus_b.ifu_req_ready = 1'b1;
        check32("b_first_req", {31'b0, bus_b.ifu_req_valid}, 1);
        check32("b_first_addr", bus_b.ifu_addr, RPC);
        @(negedge clk);
        bus_b.ifu_req_ready = 1'b0;
        bus_b.ifu_rsp_valid = 1'b1;
        bus_b.ifu_rdata     = 32'h0050_0093;
        check32("b_no_early_commit", {31'b0, b_cv}, 0);
        @(negedge clk);
        bus_b.ifu_rsp_valid = 1'b0;
        check32("b_commit_cycle3", {31'b0, b_cv}, 1);
        check32("b_commit_pc", b_cpc, RPC);
        check32("b_commit_inst0", b_cinst, 32'h0050_0093);
        @(negedge clk);
        check32("b_pc_after", b_pc, RPC + 4);
        b_exec(enc_r(5'd0, 5'd1, 5'd10));
        b_exec(EBREAK_INST);
        @(negedge clk);
        check32("b_ebreak_halt", {31'b0, b_halt}, 1);
        check32("b_ebreak_trap", {31'b0, b_trap}, 0);
        check32("b_ebreak_code", b_hcode, 32'd5);

        // RV32E: x17 does not exist
        reset_b();
        b_exec(enc_i(12'd1, 5'd0, 5'd17, 7'b0010011));
        @(negedge clk);
        check32("b_e_halt", {31'b0, b_halt}, 1);
        check32("b_e_trap", {31'b0, b_trap}, 1);
        check32("b_e_pc", b_pc, RPC);

        // Fetch timeout after 8 cycles in WAIT
        reset_b();
        bus_b.ifu_req_ready = 1'b1;
        @(negedge clk);
        bus_b.ifu_req_ready = 1'b0;
        repeat (7) begin
            @(negedge clk);
            check32("b_to_no_commit", {31'b0, b_cv}, 0);
        end
        check32("b_to_not_yet", {31'b0, b_halt}, 0);
        @(negedge clk);
        check32("b_to_halt", {31'b0, b_halt}, 1);
        check32("b_to_trap", {31'b0, b_trap}, 1);

        // Reset while in WAIT: late response must be ignored
        reset_b();
        bus_b.ifu_req_ready = 1'b1;
        @(negedge clk);
        bus_b.ifu_req_ready = 1'b0;
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        rst_b = 1'b0;
        bus_b.ifu_rsp_valid = 1'b1;
        bus_b.ifu_rdata     = 32'h0050_0093;
        @(negedge clk);
        bus_b.ifu_rsp_valid = 1'b0;
        repeat (3) begin
            check32("b_mw_no_commit", {31'b0, b_cv}, 0);
            check32("b_mw_req", {31'b0, bus_b.ifu_req_valid}, 1);
            check32("b_mw_addr", bus_b.ifu_addr, RPC);
            @(negedge clk);
        end
        b_exec(EBREAK_INST);
        check32("b_mw_commit_pc", b_cpc, RPC);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
